// File: rtl/res_drain.sv
// Result FIFO drain: pops 16-bit results and streams them out high byte first.
// Optional RES_DRAIN_RELU_EN clamps negative results to zero on capture.
module res_drain #(
    parameter int NUM_RESULTS = 1352,
    parameter int COUNT_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               fifo_empty,
    input  logic [15:0]        fifo_result_out,
    output logic               fifo_renable,
    output logic [7:0]         byte_out,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] sent_count
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        LATCH,
        SEND_HI,
        SEND_LO,
        DONE
    } state_t;

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(NUM_RESULTS - 1);

    state_t             state, state_nxt;
    logic [15:0]        data_reg, data_nxt;
    logic [COUNT_W-1:0] count_q, count_nxt;
    logic [15:0]        latch_val;

`ifdef RES_DRAIN_RELU_EN
    assign latch_val = fifo_result_out[15] ? 16'h0000 : fifo_result_out;
`else
    assign latch_val = fifo_result_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_reg <= '0;
            count_q  <= '0;
        end else begin
            state    <= state_nxt;
            data_reg <= data_nxt;
            count_q  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_reg;
        count_nxt = count_q;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = CHECK;
                    count_nxt = '0;
                end
            end
            CHECK: begin
                if (!fifo_empty) state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = LATCH;
            end
            LATCH: begin
                data_nxt  = latch_val;
                state_nxt = SEND_HI;
            end
            SEND_HI: begin
                if (byte_ready) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                if (byte_ready) begin
                    count_nxt = count_q + 1'b1;
                    state_nxt = (count_q == LAST) ? DONE : CHECK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Moore outputs only; byte_out is forced to zero when not presenting data
    always_comb begin
        fifo_renable = 1'b0;
        byte_out     = 8'h00;
        byte_valid   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            FETCH: begin
                fifo_renable = 1'b1;
            end
            SEND_HI: begin
                byte_valid = 1'b1;
                byte_out   = data_reg[15:8];
            end
            SEND_LO: begin
                byte_valid = 1'b1;
                byte_out   = data_reg[7:0];
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign sent_count = count_q;

endmodule

// File: tb/tb_res_drain.sv
// Directed bench for res_drain with a registered-read FIFO model and byte sink.
module tb_res_drain;

    localparam int NR = 1352;
    localparam int CW = 11;

    logic          tb_clk;
    logic          rst;
    logic          start;
    logic          fifo_empty;
    logic [15:0]   fifo_result_out = 16'h0000;
    logic          fifo_renable;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] sent_count;

    res_drain #(.NUM_RESULTS(NR), .COUNT_W(CW)) dut (
        .clk             (tb_clk),
        .rst             (rst),
        .start           (start),
        .fifo_empty      (fifo_empty),
        .fifo_result_out (fifo_result_out),
        .fifo_renable    (fifo_renable),
        .byte_out        (byte_out),
        .byte_valid      (byte_valid),
        .byte_ready      (byte_ready),
        .busy            (busy),
        .done            (done),
        .sent_count      (sent_count)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    logic [15:0] mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_cnt = 0;
    int          rd_empty_err = 0;
    logic [7:0]  rx [0:4095];
    int          rx_n = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Registered-read FIFO and byte sink, both sampled on the DUT clock edge
    always @(posedge tb_clk) begin
        if (fifo_renable) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                rd_empty_err <= rd_empty_err + 1;
            end else begin
                fifo_result_out <= mem[rd_ptr % 4096];
                rd_ptr <= rd_ptr + 1;
            end
        end
        if (byte_valid && byte_ready && !rst) begin
            rx[rx_n % 4096] <= byte_out;
            rx_n <= rx_n + 1;
        end
    end

    task automatic tick();
        @(negedge tb_clk);
    endtask

    task automatic push(input logic [15:0] d);
        mem[wr_ptr % 4096] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_n < n && k < budget) begin
            tick();
            k++;
        end
        check("rx_wait", rx_n, n);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;

    vec_t        vecs [6];
    logic        bp_rdy [6];
    logic [7:0]  bp_exp [6];
    int          base;
    int          n;
    int          errs;
    logic [15:0] v;

    initial begin
`ifdef RES_DRAIN_RELU_EN
        vecs[0] = '{16'hFFF6, 8'h00, 8'h00};
        vecs[2] = '{16'h8000, 8'h00, 8'h00};
`else
        vecs[0] = '{16'hFFF6, 8'hFF, 8'hF6};
        vecs[2] = '{16'h8000, 8'h80, 8'h00};
`endif
        vecs[1] = '{16'h0123, 8'h01, 8'h23};
        vecs[3] = '{16'h7FFF, 8'h7F, 8'hFF};
        vecs[4] = '{16'h00FF, 8'h00, 8'hFF};
        vecs[5] = '{16'h0000, 8'h00, 8'h00};
        bp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bp_exp = '{8'h00, 8'h00, 8'h00, 8'h44, 8'h44, 8'h44};

        rst        = 1'b1;
        start      = 1'b0;
        byte_ready = 1'b0;
        push(16'h07E5);

        // Reset with a non-empty FIFO
        tick();
        tick();
        check("rst_valid", byte_valid, 0);
        check("rst_out", {fifo_renable, busy, done, byte_out}, 0);
        check("rst_count", sent_count, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("idle_busy", busy, 0);
        check("idle_reads", rd_cnt, 0);

        // Single result and first-byte latency
        byte_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("check_busy", busy, 1);
        n = 0;
        while (!byte_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, 3);
        check("single_hi", byte_out, 8'h07);
        tick();
        check("single_lo", {byte_valid, byte_out}, {1'b1, 8'hE5});
        tick();
        check("single_cnt", sent_count, 1);
        check("single_back", {busy, byte_valid}, 2'b10);
        tick();
        tick();
        check("empty_reads", rd_cnt, 1);

        // Backpressure: 4 cycles stalled, then ready 1-in-3
        byte_ready = 1'b0;
        base = rx_n;
        push(16'h0044);
        n = 0;
        while (!byte_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("bp_hold", {byte_valid, byte_out}, {1'b1, 8'h00});
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            byte_ready = bp_rdy[i];
            check("bp_pat", {byte_valid, byte_out}, {1'b1, bp_exp[i]});
            tick();
        end
        byte_ready = 1'b1;
        check("bp_rx_n", rx_n - base, 2);
        check("bp_bytes", {rx[base], rx[base+1]}, 16'h0044);
        check("bp_reads", rd_cnt, 2);

        // Table of data patterns streamed at full rate
        for (int i = 0; i < 6; i++) begin
            base = rx_n;
            push(vecs[i].data);
            wait_rx(base + 2, 30);
            check($sformatf("vec%0d", i), {rx[base], rx[base+1]},
                  {vecs[i].exp_hi, vecs[i].exp_lo});
        end
        tick();
        check("vec_cnt", sent_count, 8);

        // Start ignored mid-frame, then reset mid-frame
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_cnt", {busy, sent_count}, 0);
        base = rx_n;
        for (int i = 1; i <= 10; i++) push(16'h0A00 + 16'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(sent_count == 4 && byte_valid && rx_n == base + 9) && n < 200) begin
            tick();
            n++;
        end
        check("r5_lo", byte_out, 8'h05);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_start", {busy, done, sent_count}, {2'b10, 11'd5});
        check("r5_hi", rx[base+8], 8'h0A);
        n = 0;
        while (!(sent_count == 9 && byte_valid && rx_n == base + 18) && n < 200) begin
            tick();
            n++;
        end
        check("r10_hi", byte_out, 8'h0A);
        byte_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        check("mid_rst", {byte_valid, busy, done, fifo_renable}, 0);
        check("mid_cnt", sent_count, 0);
        tick();
        check("mid_reads", rd_cnt, wr_ptr);

        // Full frame of NR results
        base = rx_n;
        for (int i = 1; i <= NR; i++) push(16'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 8000) begin
            tick();
            n++;
        end
        check("frame_cycles", n, 5 * NR);
        check("frame_done", {done, busy}, 2'b10);
        check("frame_cnt", sent_count, NR);
        check("frame_rx_n", rx_n - base, 2 * NR);
        errs = 0;
        for (int i = 1; i <= NR; i++) begin
            v = 16'(i);
            if (rx[base + 2*i - 2] !== v[15:8] || rx[base + 2*i - 1] !== v[7:0])
                errs++;
        end
        check("frame_bytes", errs, 0);
        tick();
        tick();
        check("done_hold", {done, sent_count}, {1'b1, 11'd1352});

        // Second start clears the count and runs again
        base = rx_n;
        push(16'h0BCD);
        push(16'h0EF0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart", {done, busy, sent_count}, {2'b01, 11'd0});
        wait_rx(base + 4, 40);
        tick();
        check("restart_bytes", {rx[base], rx[base+1], rx[base+2], rx[base+3]},
              32'h0BCD0EF0);
        check("restart_cnt", sent_count, 2);
        check("empty_read_err", rd_empty_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/res_drain.md
Name: res_drain

Overview:
- Downstream consumer of the result FIFO (16-bit results, registered read, `empty` flag).
- Pops one result at a time, splits it into two bytes (high byte first) and presents them on a valid/ready byte stream to the host-side transmit interface.
- Counts results per frame and flags `done` after NUM_RESULTS results have been fully sent.

Parameters:
- NUM_RESULTS, 1352, results per frame; default matches FIFO depth (26x26x2 feature map).
- COUNT_W, 11, width of sent_count; must satisfy 2^COUNT_W >= NUM_RESULTS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; begins a frame. Honoured only in IDLE or DONE.
- fifo_empty  in  1  result FIFO empty flag.
- fifo_result_out  in  16  result FIFO read data; valid the cycle after a renable cycle.
- fifo_renable  out  1  result FIFO read strobe; exactly one cycle per pop.
- byte_out  out  8  outgoing byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  sink accepts byte; transfer occurs on a rising edge where valid and ready are both 1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- sent_count  out  COUNT_W  results fully transmitted in the current frame.

Behaviour:
- Synchronous active-high reset: state=IDLE, data_reg=0, sent_count=0. All outputs are 0 during and immediately after reset.
- All outputs are Moore outputs decoded from the state register plus data_reg/sent_count. No combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start -> CHECK, sent_count<=0.
  - CHECK: !fifo_empty -> FETCH; otherwise stay.
  - FETCH: fifo_renable=1 for this cycle only; -> LATCH unconditionally.
  - LATCH: data_reg<=fifo_result_out at the closing edge; -> SEND_HI.
  - SEND_HI: byte_valid=1, byte_out=data_reg[15:8]; byte_ready -> SEND_LO; otherwise hold.
  - SEND_LO: byte_valid=1, byte_out=data_reg[7:0]. On byte_ready, sent_count increments. If sent_count==NUM_RESULTS-1 -> DONE, otherwise -> CHECK.
  - DONE: done=1; sent_count holds NUM_RESULTS; start -> CHECK with sent_count<=0.
- Latency: if the FIFO is non-empty, the first byte_valid appears 3 cycles after entering CHECK (CHECK, FETCH, LATCH, then SEND_HI). Peak throughput is 1 result per 5 cycles when byte_ready is held high.
- Handshake: while byte_valid=1 and byte_ready=0, byte_out and state hold stable. byte_ready while byte_valid=0 is ignored.
- Empty FIFO: fifo_renable is never asserted while fifo_empty=1, so there are no reads on empty. The block waits in CHECK indefinitely.
- start outside IDLE/DONE is ignored; the frame continues unaffected.
- fifo_empty toggling during FETCH/LATCH/SEND_* has no effect; it is sampled only in CHECK.
- Reset mid-frame: next state is IDLE and sent_count=0. A result already popped but not yet fully sent is discarded; no FIFO rollback.
- sent_count never exceeds NUM_RESULTS and does not wrap.

Optional Feature:
- Macro: RES_DRAIN_RELU_EN.
- Defined: in LATCH, if fifo_result_out[15]==1 (negative in two's complement), data_reg<=16'h0000; otherwise it is captured unchanged.
- Not defined: data_reg<=fifo_result_out verbatim.
- Timing, state sequence and counts are identical in both builds.

Test Plan:
1. Reset: assert rst 2 cycles with fifo_empty=0 -> all outputs 0, fifo_renable never asserted; after release, stays IDLE without start.
2. Single result: FIFO model holds 16'h07E5, start pulse, byte_ready=1 -> one renable pulse; bytes 8'h07 then 8'h E5 on consecutive cycles; sent_count=1; returns to CHECK; fifo_empty=1 keeps it in CHECK with renable low.
3. Backpressure: data 16'h0044, byte_ready low 4 cycles in SEND_HI, then pulsed 1-in-3 -> byte_out stays 8'h00 until accepted, then 8'h44 holds until accepted; no extra renable.
4. Full frame: NUM_RESULTS=1352 values 1..1352 streamed, byte_ready=1 -> 2704 bytes in order {hi,lo}; done=1 and sent_count=1352 after the last low byte; busy=0; second start clears count and re-runs.
5. Mid-frame reset and start-ignore: start pulse during SEND_LO of result 5 -> ignored. rst during SEND_HI of result 10 -> IDLE, sent_count=0, byte_valid=0 next cycle.
6. RELU build: data 16'hFFF6 and 16'h0123 -> with RES_DRAIN_RELU_EN, bytes 00,00,01,23; without it, bytes FF,F6,01,23.
